// File: rtl/reaction_game_pkg.sv
// Shared types and constants for the reaction game BCD timer.
package reaction_game_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD
    } timer_state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

endpackage

// File: rtl/reaction_game_bcd_digit.sv
// One decade (0..9) counter with a ripple carry and a saturation hold.
module reaction_game_bcd_digit
    import reaction_game_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    input  logic hold9,
    output bcd_t q,
    output logic carry
);

    bcd_t digit_q;
    bcd_t digit_d;

    // Next value: clear wins, otherwise step 0..9 and wrap unless saturating.
    always_comb begin
        digit_d = digit_q;
        if (clr) begin
            digit_d = '0;
        end else if (inc) begin
            if (digit_q == BCD_MAX) begin
                if (!hold9) begin
                    digit_d = '0;
                end
            end else begin
                digit_d = digit_q + 4'd1;
            end
        end
    end

    // Digit register with asynchronous reset to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign q     = digit_q;
    assign carry = inc && (digit_q == BCD_MAX);

endmodule

// File: rtl/reaction_game_bcd_timer.sv
// Four-digit BCD reaction timer: start/stop/clear control, tick prescaler,
// saturation at 9999 and leading-zero blanking for the seven-segment decoders.
module reaction_game_bcd_timer
    import reaction_game_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       clr,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic [3:0] en,
    output logic       running,
    output logic       overflow
);

    localparam int CLK_DIV = CLK_HZ / TICK_HZ;
    localparam int PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

    timer_state_t state_q;
    logic         running_q;
    logic         overflow_q;
    logic [PW-1:0] prescCnt_q;
    logic [PW-1:0] prescCnt_d;

    bcd_t       digQ [4];
    logic [3:0] carry;
    logic [3:0] incVec;
    logic       tickInc;
    logic       clearDigits;
    logic       allNines;
    logic       satTick;

    // A tick only advances the count in RUN when no higher-priority pulse is present,
    // so a stop landing on the tick cycle discards the increment.
    assign tickInc     = (state_q == RUN) && (prescCnt_q == PRESC_MAX) && !clr && !start && !stop;
    assign clearDigits = clr || start;
    assign allNines    = (digQ[0] == BCD_MAX) && (digQ[1] == BCD_MAX) &&
                         (digQ[2] == BCD_MAX) && (digQ[3] == BCD_MAX);
    assign incVec      = {carry[2:0], tickInc};

    // The carry out of the top digit only fires on a tick while every digit is 9.
    assign satTick = carry[3];

    for (genvar i = 0; i < 4; i++) begin : gDigit
        reaction_game_bcd_digit uDigit (
            .clk   (clk),
            .rst   (rst),
            .clr   (clearDigits),
            .inc   (incVec[i]),
            .hold9 (allNines),
            .q     (digQ[i]),
            .carry (carry[i])
        );
    end

    // Prescaler next value: cleared by clr/start, free-runs only in RUN, holds otherwise.
    always_comb begin
        prescCnt_d = prescCnt_q;
        if (clr || start) begin
            prescCnt_d = '0;
        end else if ((state_q == RUN) && !stop) begin
            if (prescCnt_q == PRESC_MAX) begin
                prescCnt_d = '0;
            end else begin
                prescCnt_d = prescCnt_q + PW'(1);
            end
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescCnt_q <= '0;
        end else begin
            prescCnt_q <= prescCnt_d;
        end
    end

    // Control FSM with registered running/overflow flags; clr > start > stop > tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            running_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else if (clr) begin
            state_q    <= IDLE;
            running_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else if (start) begin
            state_q    <= RUN;
            running_q  <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (stop) begin
                        state_q   <= HOLD;
                        running_q <= 1'b0;
                    end else if (satTick) begin
                        state_q    <= HOLD;
                        running_q  <= 1'b0;
                        overflow_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= state_q;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    // Leading-zero blanking straight from the digit registers.
    always_comb begin
        en    = 4'b0001;
        en[3] = (digQ[3] != 4'd0);
        en[2] = en[3] || (digQ[2] != 4'd0);
        en[1] = en[2] || (digQ[1] != 4'd0);
    end

    assign digit0   = digQ[0];
    assign digit1   = digQ[1];
    assign digit2   = digQ[2];
    assign digit3   = digQ[3];
    assign running  = running_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_reaction_game_bcd_timer.sv
// Scoreboard bench for reaction_game_bcd_timer: dut A runs at CLK_DIV=10,
// dut B at CLK_DIV=2 so the 10000-tick saturation run stays short.
module tb_reaction_game_bcd_timer;

    logic clk = 1'b0;
    logic rst;
    logic startA, stopA, clrA;
    logic startB, stopB, clrB;

    logic [3:0] dA0, dA1, dA2, dA3, enA;
    logic       runA, ovfA;
    logic [3:0] dB0, dB1, dB2, dB3, enB;
    logic       runB, ovfB;

    typedef struct packed {
        logic        sel;
        logic [15:0] digits;
        logic [3:0]  en;
        logic        running;
        logic        overflow;
    } exp_t;

    exp_t        expQ [$];
    string       nameQ [$];
    exp_t        expItem;
    string       expName;
    logic [21:0] actVec;
    logic [21:0] reqVec;
    int          total = 0;
    int          bad = 0;

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    reaction_game_bcd_timer #(.CLK_HZ(10), .TICK_HZ(1)) dutA (
        .clk      (clk),
        .rst      (rst),
        .start    (startA),
        .stop     (stopA),
        .clr      (clrA),
        .digit0   (dA0),
        .digit1   (dA1),
        .digit2   (dA2),
        .digit3   (dA3),
        .en       (enA),
        .running  (runA),
        .overflow (ovfA)
    );

    reaction_game_bcd_timer #(.CLK_HZ(2), .TICK_HZ(1)) dutB (
        .clk      (clk),
        .rst      (rst),
        .start    (startB),
        .stop     (stopB),
        .clr      (clrB),
        .digit0   (dB0),
        .digit1   (dB1),
        .digit2   (dB2),
        .digit3   (dB3),
        .en       (enB),
        .running  (runB),
        .overflow (ovfB)
    );

    // Integer to packed BCD by division, independent of the ripple counter.
    function automatic logic [15:0] toBcd(input int k);
        return {4'(k / 1000), 4'((k / 100) % 10), 4'((k / 10) % 10), 4'(k % 10)};
    endfunction

    // Leading-zero blanking model.
    function automatic logic [3:0] enOf(input logic [15:0] d);
        logic [3:0] e;
        e    = 4'b0001;
        e[3] = (d[15:12] != 4'd0);
        e[2] = e[3] || (d[11:8] != 4'd0);
        e[1] = e[2] || (d[7:4] != 4'd0);
        return e;
    endfunction

    // Advance to just after the n-th following rising edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Queue an expected response; the monitor compares it at the next falling edge.
    task automatic checkOutput(input logic sel, input string name, input logic [15:0] d,
                               input logic [3:0] e, input logic r, input logic o);
        exp_t item;
        item.sel      = sel;
        item.digits   = d;
        item.en       = e;
        item.running  = r;
        item.overflow = o;
        expQ.push_back(item);
        nameQ.push_back(name);
    endtask

    // One-cycle pulse on a control input of dut A (sel=0) or B (sel=1): 0 start, 1 stop, 2 clr.
    task automatic applyStimulus(input logic sel, input int kind);
        if (!sel) begin
            startA = (kind == 0);
            stopA  = (kind == 1);
            clrA   = (kind == 2);
        end else begin
            startB = (kind == 0);
            stopB  = (kind == 1);
            clrB   = (kind == 2);
        end
        cyc(1);
        startA = 1'b0; stopA = 1'b0; clrA = 1'b0;
        startB = 1'b0; stopB = 1'b0; clrB = 1'b0;
    endtask

    // Monitor: pop every pending expectation and compare against the selected dut.
    always @(negedge clk) begin
        while (expQ.size() > 0) begin
            expItem = expQ.pop_front();
            expName = nameQ.pop_front();
            if (expItem.sel)
                actVec = {dB3, dB2, dB1, dB0, enB, runB, ovfB};
            else
                actVec = {dA3, dA2, dA1, dA0, enA, runA, ovfA};
            reqVec = {expItem.digits, expItem.en, expItem.running, expItem.overflow};
            total++;
            if (actVec !== reqVec) begin
                bad++;
                $display("[TB] FAIL %s: got digits=%h en=%b run=%b ovf=%b, want digits=%h en=%b run=%b ovf=%b",
                         expName, actVec[21:6], actVec[5:2], actVec[1], actVec[0],
                         reqVec[21:6], reqVec[5:2], reqVec[1], reqVec[0]);
            end
        end
    end

    // Directed stimulus sequence.
    initial begin
        rst = 1'b1;
        startA = 1'b0; stopA = 1'b0; clrA = 1'b0;
        startB = 1'b0; stopB = 1'b0; clrB = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset then idle.
        cyc(50);
        checkOutput(0, "idle_A", 16'h0000, 4'b0001, 1'b0, 1'b0);
        checkOutput(1, "idle_B", 16'h0000, 4'b0001, 1'b0, 1'b0);
        applyStimulus(0, 1);
        checkOutput(0, "stop_in_idle", 16'h0000, 4'b0001, 1'b0, 1'b0);

        // Start, 1230 cycles, stop: frozen at 0123.
        applyStimulus(0, 0);
        checkOutput(0, "start_zero", 16'h0000, 4'b0001, 1'b1, 1'b0);
        cyc(9);
        checkOutput(0, "before_first_tick", 16'h0000, 4'b0001, 1'b1, 1'b0);
        cyc(1);
        checkOutput(0, "first_tick", 16'h0001, 4'b0001, 1'b1, 1'b0);
        cyc(1220);
        checkOutput(0, "count_123", 16'h0123, 4'b0111, 1'b1, 1'b0);
        applyStimulus(0, 1);
        checkOutput(0, "stop_123", 16'h0123, 4'b0111, 1'b0, 1'b0);
        cyc(100);
        checkOutput(0, "hold_123", 16'h0123, 4'b0111, 1'b0, 1'b0);

        // Decade carries through 0009->0010 and 0099->0100.
        applyStimulus(0, 0);
        checkOutput(0, "seq_start", 16'h0000, 4'b0001, 1'b1, 1'b0);
        for (int k = 1; k <= 105; k++) begin
            cyc(10);
            checkOutput(0, "seq", toBcd(k), enOf(toBcd(k)), 1'b1, 1'b0);
            if (k == 9)   checkOutput(0, "seq_0009", 16'h0009, 4'b0001, 1'b1, 1'b0);
            if (k == 10)  checkOutput(0, "seq_0010", 16'h0010, 4'b0011, 1'b1, 1'b0);
            if (k == 99)  checkOutput(0, "seq_0099", 16'h0099, 4'b0011, 1'b1, 1'b0);
            if (k == 100) checkOutput(0, "seq_0100", 16'h0100, 4'b0111, 1'b1, 1'b0);
        end
        applyStimulus(0, 1);
        checkOutput(0, "seq_stop", 16'h0105, 4'b0111, 1'b0, 1'b0);

        // Restart during RUN, then stop on the tick cycle.
        applyStimulus(0, 0);
        cyc(500);
        checkOutput(0, "count_50", 16'h0050, 4'b0011, 1'b1, 1'b0);
        applyStimulus(0, 0);
        checkOutput(0, "restart", 16'h0000, 4'b0001, 1'b1, 1'b0);
        cyc(30);
        checkOutput(0, "count_3", 16'h0003, 4'b0001, 1'b1, 1'b0);
        cyc(9);
        checkOutput(0, "pre_tick_3", 16'h0003, 4'b0001, 1'b1, 1'b0);
        applyStimulus(0, 1);
        checkOutput(0, "stop_on_tick", 16'h0003, 4'b0001, 1'b0, 1'b0);
        cyc(20);
        checkOutput(0, "stop_on_tick_hold", 16'h0003, 4'b0001, 1'b0, 1'b0);

        // Asynchronous reset between edges at 0042.
        applyStimulus(0, 0);
        cyc(420);
        checkOutput(0, "count_42", 16'h0042, 4'b0011, 1'b1, 1'b0);
        @(negedge clk);
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        checkOutput(0, "async_reset", 16'h0000, 4'b0001, 1'b0, 1'b0);
        cyc(5);
        checkOutput(0, "after_reset_idle", 16'h0000, 4'b0001, 1'b0, 1'b0);

        // clr from HOLD.
        applyStimulus(0, 0);
        cyc(50);
        applyStimulus(0, 1);
        checkOutput(0, "hold_5", 16'h0005, 4'b0001, 1'b0, 1'b0);
        applyStimulus(0, 2);
        checkOutput(0, "clr_from_hold", 16'h0000, 4'b0001, 1'b0, 1'b0);

        // Saturation on dut B (CLK_DIV=2).
        applyStimulus(1, 0);
        checkOutput(1, "sat_start", 16'h0000, 4'b0001, 1'b1, 1'b0);
        cyc(2 * 9999);
        checkOutput(1, "sat_9999", 16'h9999, 4'b1111, 1'b1, 1'b0);
        cyc(1);
        checkOutput(1, "sat_pre_tick", 16'h9999, 4'b1111, 1'b1, 1'b0);
        cyc(1);
        checkOutput(1, "sat_overflow", 16'h9999, 4'b1111, 1'b0, 1'b1);
        applyStimulus(1, 1);
        checkOutput(1, "sat_stop", 16'h9999, 4'b1111, 1'b0, 1'b1);
        cyc(10);
        checkOutput(1, "sat_hold", 16'h9999, 4'b1111, 1'b0, 1'b1);
        applyStimulus(1, 2);
        checkOutput(1, "sat_clr", 16'h0000, 4'b0001, 1'b0, 1'b0);

        cyc(3);
        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain: got pending=%0d, want pending=0", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
